// File: rtl/regfile_mp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised 3-read / 2-write register file with optional write
//            bypass, pending-write scoreboard and a post-reset init walker.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int BYPASS    = 1,
    parameter int INIT_MODE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] reg_R_addr_A,
    input  logic [ADDR_W-1:0] reg_R_addr_B,
    input  logic [ADDR_W-1:0] reg_R_addr_C,
    output logic [DATA_W-1:0] rdata_A,
    output logic [DATA_W-1:0] rdata_B,
    output logic [DATA_W-1:0] rdata_C,
    input  logic              reg_we_0,
    input  logic [ADDR_W-1:0] reg_W_addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic              reg_we_1,
    input  logic [ADDR_W-1:0] reg_W_addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              pend_A,
    output logic              pend_B,
    output logic              pend_C,
    output logic              init_busy
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam int                NUM_RD    = 3;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_init_cnt;
    logic                r_init_busy;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:1]    r_pend;

    logic                w_ready;
    logic                w_wr0;
    logic                w_wr1;
    logic                w_rsv;
    logic [DATA_W-1:0]   w_init_val;
    logic [DEPTH-1:1]    w_clr;
    logic [DEPTH-1:1]    w_set;
    logic [DEPTH-1:0]    w_pend_full;

    logic [ADDR_W-1:0]   w_raddr [NUM_RD];
    logic [DATA_W-1:0]   w_rdata [NUM_RD];
    logic                w_rpend [NUM_RD];

    assign w_ready     = (r_state == ST_READY);
    assign w_wr0       = w_ready && reg_we_0 && (reg_W_addr_0 != '0);
    assign w_wr1       = w_ready && reg_we_1 && (reg_W_addr_1 != '0);
    assign w_rsv       = w_ready && rsv_en   && (rsv_addr     != '0);
    assign w_pend_full = {r_pend, 1'b0};
    assign init_busy   = r_init_busy;

    always_comb begin
        w_init_val = '0;
        if (INIT_MODE != 0) begin
            w_init_val = DATA_W'(r_init_cnt);
        end
    end

    // Init walker: visits 1..DEPTH-1 once, then READY until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= ADDR_W'(1);
            r_init_busy <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + ADDR_W'(1);
                    if (r_init_cnt == LAST_ADDR) begin
                        r_state     <= ST_READY;
                        r_init_busy <= 1'b0;
                    end
                end
                ST_READY: begin
                    r_state <= ST_READY;
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_init_busy <= 1'b1;
                end
            endcase
        end
    end

    // Array has no reset; rst_n gating drops any write on an edge seen in reset.
    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == ST_INIT) begin
                r_mem[r_init_cnt] <= w_init_val;
            end else begin
                if (w_wr0) begin
                    r_mem[reg_W_addr_0] <= wdata_0;
                end
                if (w_wr1) begin
                    r_mem[reg_W_addr_1] <= wdata_1;
                end
            end
        end
    end

    always_comb begin
        w_clr = '0;
        w_set = '0;
        if (w_wr0) begin
            w_clr[reg_W_addr_0] = 1'b1;
        end
        if (w_wr1) begin
            w_clr[reg_W_addr_1] = 1'b1;
        end
        if (w_rsv) begin
            w_set[rsv_addr] = 1'b1;
        end
    end

    // A reserve on the same edge as a retiring write belongs to a newer producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    assign w_raddr[0] = reg_R_addr_A;
    assign w_raddr[1] = reg_R_addr_B;
    assign w_raddr[2] = reg_R_addr_C;

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic w_hit0;
            logic w_hit1;

            assign w_hit0 = (BYPASS != 0) && reg_we_0 && (reg_W_addr_0 == w_raddr[p]);
            assign w_hit1 = (BYPASS != 0) && reg_we_1 && (reg_W_addr_1 == w_raddr[p]);

            always_comb begin
                w_rdata[p] = '0;
                w_rpend[p] = 1'b0;
                if (!r_init_busy && (w_raddr[p] != '0)) begin
                    if (w_hit1) begin
                        w_rdata[p] = wdata_1;
                    end else if (w_hit0) begin
                        w_rdata[p] = wdata_0;
                    end else begin
                        w_rdata[p] = r_mem[w_raddr[p]];
                    end
                    w_rpend[p] = w_pend_full[w_raddr[p]] && !(w_hit0 || w_hit1);
                end
            end
        end
    endgenerate

    assign rdata_A = w_rdata[0];
    assign rdata_B = w_rdata[1];
    assign rdata_C = w_rdata[2];
    assign pend_A  = w_rpend[0];
    assign pend_B  = w_rpend[1];
    assign pend_C  = w_rpend[2];

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Self-checking bench for regfile_mp (bypass and non-bypass builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] ra [3];
    logic          we0, we1, rsv_en;
    logic [AW-1:0] wa0, wa1, rsv_addr;
    logic [DW-1:0] wd0, wd1;

    logic [DW-1:0] rd_bp [3];
    logic [DW-1:0] rd_nb [3];
    logic          pd_bp [3];
    logic          pd_nb [3];
    logic          busy_bp, busy_nb;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .INIT_MODE(1)) u_dut_bp (
        .clk(clk), .rst_n(rst_n),
        .reg_R_addr_A(ra[0]), .reg_R_addr_B(ra[1]), .reg_R_addr_C(ra[2]),
        .rdata_A(rd_bp[0]), .rdata_B(rd_bp[1]), .rdata_C(rd_bp[2]),
        .reg_we_0(we0), .reg_W_addr_0(wa0), .wdata_0(wd0),
        .reg_we_1(we1), .reg_W_addr_1(wa1), .wdata_1(wd1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .pend_A(pd_bp[0]), .pend_B(pd_bp[1]), .pend_C(pd_bp[2]),
        .init_busy(busy_bp)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0), .INIT_MODE(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n),
        .reg_R_addr_A(ra[0]), .reg_R_addr_B(ra[1]), .reg_R_addr_C(ra[2]),
        .rdata_A(rd_nb[0]), .rdata_B(rd_nb[1]), .rdata_C(rd_nb[2]),
        .reg_we_0(we0), .reg_W_addr_0(wa0), .wdata_0(wd0),
        .reg_we_1(we1), .reg_W_addr_1(wa1), .wdata_1(wd1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .pend_A(pd_nb[0]), .pend_B(pd_nb[1]), .pend_C(pd_nb[2]),
        .init_busy(busy_nb)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: index 0 = bypass/init-to-index build, 1 = plain/init-to-zero build
    logic [DW-1:0] mm [2][DEPTH];
    bit            mpend [DEPTH];
    bit            mbusy;
    int            mcnt;
    bit            m_bp [2] = '{1'b1, 1'b0};
    bit            m_im [2] = '{1'b1, 1'b0};

    function automatic logic [DW-1:0] exp_rd(int k, logic [AW-1:0] a);
        if (mbusy || a == 0) return '0;
        if (m_bp[k] && we1 && wa1 == a) return wd1;
        if (m_bp[k] && we0 && wa0 == a) return wd0;
        return mm[k][a];
    endfunction

    function automatic logic exp_pd(int k, logic [AW-1:0] a);
        if (mbusy || a == 0) return 1'b0;
        if (m_bp[k] && ((we1 && wa1 == a) || (we0 && wa0 == a))) return 1'b0;
        return mpend[a];
    endfunction

    task automatic model_reset();
        mbusy = 1'b1;
        mcnt  = 1;
        for (int i = 0; i < DEPTH; i++) mpend[i] = 1'b0;
    endtask

    task automatic model_edge();
        if (mbusy) begin
            for (int k = 0; k < 2; k++) mm[k][mcnt] = m_im[k] ? DW'(mcnt) : '0;
            if (mcnt == DEPTH - 1) mbusy = 1'b0;
            mcnt++;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (we0 && wa0 != 0) mm[k][wa0] = wd0;
                if (we1 && wa1 != 0) mm[k][wa1] = wd1;
            end
            if (we0 && wa0 != 0) mpend[wa0] = 1'b0;
            if (we1 && wa1 != 0) mpend[wa1] = 1'b0;
            if (rsv_en && rsv_addr != 0) mpend[rsv_addr] = 1'b1;
        end
    endtask

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("%s rd_bp[%0d]", tag, p), rd_bp[p], exp_rd(0, ra[p]));
            chk($sformatf("%s rd_nb[%0d]", tag, p), rd_nb[p], exp_rd(1, ra[p]));
            chk($sformatf("%s pd_bp[%0d]", tag, p), DW'(pd_bp[p]), DW'(exp_pd(0, ra[p])));
            chk($sformatf("%s pd_nb[%0d]", tag, p), DW'(pd_nb[p]), DW'(exp_pd(1, ra[p])));
        end
        chk($sformatf("%s busy_bp", tag), DW'(busy_bp), DW'(mbusy));
        chk($sformatf("%s busy_nb", tag), DW'(busy_nb), DW'(mbusy));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic step(string tag);
        #1;
        chk_all(tag);
        cyc();
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; rsv_en = 0;
        wa0 = '0; wa1 = '0; rsv_addr = '0; wd0 = '0; wd1 = '0;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
        return AW'($urandom_range(0, 3));
    endfunction

    typedef struct {
        logic          we0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          we1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          rsv;
        logic [AW-1:0] rsva;
        logic [AW-1:0] raddr;
        logic [DW-1:0] e_bp;
        logic [DW-1:0] e_nb;
        logic          p_bp;
        logic          p_nb;
    } vec_t;

    function automatic vec_t mkv(logic w0, int a0, logic [DW-1:0] d0,
                                 logic w1, int a1, logic [DW-1:0] d1,
                                 logic rs, int rsa, int rda,
                                 logic [DW-1:0] ebp, logic [DW-1:0] enb,
                                 logic pbp, logic pnb);
        vec_t v;
        v.we0 = w0; v.a0 = AW'(a0); v.d0 = d0;
        v.we1 = w1; v.a1 = AW'(a1); v.d1 = d1;
        v.rsv = rs; v.rsva = AW'(rsa); v.raddr = AW'(rda);
        v.e_bp = ebp; v.e_nb = enb; v.p_bp = pbp; v.p_nb = pnb;
        return v;
    endfunction

    localparam int NV = 22;
    vec_t vt [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Starting from a freshly initialised file: bp build reg i = i, nb build reg i = 0
        vt[0]  = mkv(0, 0, 0,            0, 0, 0,        0, 0, 13, 13,           0,           0, 0);
        vt[1]  = mkv(0, 0, 0,            0, 0, 0,        0, 0, 31, 31,           0,           0, 0);
        vt[2]  = mkv(0, 0, 0,            0, 0, 0,        0, 0, 0,  0,            0,           0, 0);
        vt[3]  = mkv(1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 0, 5,  32'hDEADBEEF, 0,           0, 0);
        vt[4]  = mkv(0, 0, 0,            0, 0, 0,        0, 0, 5,  32'hDEADBEEF, 32'hDEADBEEF,0, 0);
        vt[5]  = mkv(1, 7, 32'h11,       1, 7, 32'h22,   0, 0, 7,  32'h22,       0,           0, 0);
        vt[6]  = mkv(0, 0, 0,            0, 0, 0,        0, 0, 7,  32'h22,       32'h22,      0, 0);
        vt[7]  = mkv(1, 0, 32'h55,       0, 0, 0,        0, 0, 0,  0,            0,           0, 0);
        vt[8]  = mkv(0, 0, 0,            0, 0, 0,        0, 0, 0,  0,            0,           0, 0);
        vt[9]  = mkv(0, 0, 0,            0, 0, 0,        1, 9, 9,  9,            0,           0, 0);
        vt[10] = mkv(0, 0, 0,            0, 0, 0,        0, 0, 9,  9,            0,           1, 1);
        vt[11] = mkv(1, 9, 32'h77,       0, 0, 0,        0, 0, 9,  32'h77,       0,           0, 1);
        vt[12] = mkv(0, 0, 0,            0, 0, 0,        0, 0, 9,  32'h77,       32'h77,      0, 0);
        vt[13] = mkv(0, 0, 0,            1, 9, 32'h88,   1, 9, 9,  32'h88,       32'h77,      0, 0);
        vt[14] = mkv(0, 0, 0,            0, 0, 0,        0, 0, 9,  32'h88,       32'h88,      1, 1);
        vt[15] = mkv(0, 0, 0,            0, 0, 0,        1, 9, 9,  32'h88,       32'h88,      1, 1);
        vt[16] = mkv(0, 0, 0,            0, 0, 0,        0, 0, 9,  32'h88,       32'h88,      1, 1);
        vt[17] = mkv(0, 0, 0,            0, 0, 0,        1, 0, 0,  0,            0,           0, 0);
        vt[18] = mkv(1, 12, 32'h1212,    1, 13, 32'h1313,0, 0, 12, 32'h1212,     0,           0, 0);
        vt[19] = mkv(0, 0, 0,            0, 0, 0,        0, 0, 13, 32'h1313,     32'h1313,    0, 0);
        vt[20] = mkv(1, 3, 32'h33,       0, 0, 0,        1, 3, 3,  32'h33,       0,           0, 0);
        vt[21] = mkv(0, 0, 0,            0, 0, 0,        0, 0, 3,  32'h33,       32'h33,      1, 1);

        idle();
        for (int p = 0; p < 3; p++) ra[p] = AW'(p + 1);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++) mm[k][i] = 'x;
        model_reset();
        #12;
        chk_all("reset");
        chk("reset busy", DW'(busy_bp), 1);

        // Init length from rst_n release
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step("init");
            n++;
            if (!busy_bp) break;
        end
        chk("init edge count", DW'(n), 31);

        foreach (vt[i]) begin
            we0 = vt[i].we0; wa0 = vt[i].a0; wd0 = vt[i].d0;
            we1 = vt[i].we1; wa1 = vt[i].a1; wd1 = vt[i].d1;
            rsv_en = vt[i].rsv; rsv_addr = vt[i].rsva;
            for (int p = 0; p < 3; p++) ra[p] = vt[i].raddr;
            #1;
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("vec%0d rd_bp[%0d]", i, p), rd_bp[p], vt[i].e_bp);
                chk($sformatf("vec%0d rd_nb[%0d]", i, p), rd_nb[p], vt[i].e_nb);
                chk($sformatf("vec%0d pd_bp[%0d]", i, p), DW'(pd_bp[p]), DW'(vt[i].p_bp));
                chk($sformatf("vec%0d pd_nb[%0d]", i, p), DW'(pd_nb[p]), DW'(vt[i].p_nb));
            end
            chk_all($sformatf("vec%0d model", i));
            cyc();
        end

        // Reset lands during a READY write of 0x99 to register 3
        idle();
        we0 = 1; wa0 = AW'(3); wd0 = 32'h99;
        ra[0] = AW'(3); ra[1] = AW'(9); ra[2] = AW'(7);
        #1;
        chk("pre-reset bypass", rd_bp[0], 32'h99);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst busy", DW'(busy_bp), 1);
        chk("rst rdata", rd_bp[2], 0);
        chk("rst pend", DW'(pd_bp[1]), 0);
        chk_all("rst ready");
        cyc();
        #2;
        idle();
        rst_n = 1'b1;

        // Reset again ten edges into INIT
        for (int i = 0; i < 10; i++) step("init10");
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst init busy", DW'(busy_bp), 1);
        chk_all("rst init");
        cyc();
        #2;
        rst_n = 1'b1;

        // Writes and reserves to register 20 throughout INIT are dropped
        we1 = 1; wa1 = AW'(20); wd1 = 32'hAA; rsv_en = 1; rsv_addr = AW'(20);
        ra[0] = AW'(3); ra[1] = AW'(20); ra[2] = AW'(9);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step("init ign");
            n++;
            if (!busy_bp) break;
        end
        chk("reinit edge count", DW'(n), 31);
        idle();
        #1;
        chk("reg3 after reinit", rd_bp[0], 3);
        chk("reg20 after init", rd_bp[1], 20);
        chk("reg20 nb after init", rd_nb[1], 0);
        chk("pend20 after init", DW'(pd_bp[1]), 0);
        chk("pend9 cleared", DW'(pd_bp[2]), 0);
        chk_all("post init");
        cyc();

        // Randomised traffic with occasional resets
        for (int i = 0; i < 700; i++) begin
            rst_n = 1'b1;
            we0 = 1'($urandom_range(0, 1)); wa0 = rnd_addr(); wd0 = DW'($urandom);
            we1 = 1'($urandom_range(0, 1)); wa1 = rnd_addr(); wd1 = DW'($urandom);
            rsv_en = ($urandom_range(0, 2) == 0); rsv_addr = rnd_addr();
            for (int p = 0; p < 3; p++) ra[p] = rnd_addr();
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
